// File: rtl/sra_64b_arb_pkg.sv
// Shared types and helpers for the sra_64b round-robin scheduler.
package sra_64b_arb_pkg;

    localparam int DATA_W  = 64;
    localparam int SHAMT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Binary shift amount to the shifter's one-hot shift vector; zero shift is all-zero.
    function automatic logic [DATA_W-1:0] shamt_to_onehot(input logic [SHAMT_W-1:0] shamt);
        logic [DATA_W-1:0] v;
        v = '0;
        if (shamt != '0) begin
            v = {{(DATA_W-1){1'b0}}, 1'b1} << shamt;
        end
        return v;
    endfunction

endpackage

// File: rtl/sra_64b.sv
// 64-bit right shifter driven by a one-hot shift vector, optional output register.
module sra_64b #(
    parameter int OUT_REG = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        init_i,
    input  logic        arith_i,
    input  logic [63:0] shift_i,
    input  logic [63:0] data_i,
    output logic [63:0] data_o,
    output logic        done_o
);

    logic [5:0]         amt;
    logic signed [63:0] sdata;
    logic [63:0]        res;

    // Recover the shift amount from the one-hot vector and perform the shift.
    always_comb begin
        amt = '0;
        for (int i = 0; i < 64; i++) begin
            if (shift_i[i]) begin
                amt = amt | 6'(i);
            end
        end
        sdata = $signed(data_i) >>> amt;
        res   = arith_i ? sdata : (data_i >> amt);
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [63:0] data_q;
            logic        done_q;

            // Result lands one cycle after init, flagged by done.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    data_q <= '0;
                    done_q <= 1'b0;
                end else begin
                    done_q <= init_i;
                    if (init_i) begin
                        data_q <= res;
                    end
                end
            end

            assign data_o = data_q;
            assign done_o = done_q;
        end else begin : g_comb
            assign data_o = res;
            assign done_o = init_i;
        end
    endgenerate

endmodule

// File: rtl/sra_64b_arb_rr_arb.sv
// Round-robin grant: first valid requester at or after the pointer, circularly.
module rr_arb #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    logic [ID_W:0] cand;

    // Scan requesters starting at the pointer and take the first one asserting valid.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!any_o && req_i[cand[ID_W-1:0]]) begin
                any_o                  = 1'b1;
                gnt_o[cand[ID_W-1:0]]  = 1'b1;
                idx_o                  = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sra_64b_arb.sv
// Round-robin scheduler sharing one registered sra_64b shifter among N_REQ requesters.
module sra_64b_arb
    import sra_64b_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ-1:0]       req_arith_i,
    input  logic [N_REQ-1:0][5:0]  req_shamt_i,
    input  logic [N_REQ-1:0][63:0] req_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [63:0]            rsp_data_o,
    output logic [31:0]            op_cnt_o
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              arith_q, arith_d;
    logic [5:0]        shamt_q, shamt_d;
    logic [63:0]       data_q, data_d;
    logic [63:0]       result_q, result_d;
    logic [31:0]       op_cnt_q, op_cnt_d;

    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;

    logic              shf_init;
    logic              shf_done;
    logic [63:0]       shf_shift;
    logic [63:0]       shf_data;

    rr_arb #(
        .N_REQ (N_REQ)
    ) u_rr_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    sra_64b #(
        .OUT_REG (1)
    ) u_sra (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .init_i  (shf_init),
        .arith_i (arith_q),
        .shift_i (shf_shift),
        .data_i  (data_q),
        .data_o  (shf_data),
        .done_o  (shf_done)
    );

    // Next-state, operand capture and handshake outputs for the one-op-in-flight sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        arith_d     = arith_q;
        shamt_d     = shamt_q;
        data_d      = data_q;
        result_d    = result_q;
        op_cnt_d    = op_cnt_q;
        req_ready_o = '0;
        rsp_valid_o = 1'b0;
        shf_init    = 1'b0;
        shf_shift   = '0;
        case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted so all outputs read zero.
                if (gnt_any && rst_n_i) begin
                    req_ready_o = gnt;
                    arith_d     = req_arith_i[gnt_idx];
                    shamt_d     = req_shamt_i[gnt_idx];
                    data_d      = req_data_i[gnt_idx];
                    id_d        = gnt_idx;
                    ptr_d       = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                shf_init  = 1'b1;
                shf_shift = shamt_to_onehot(shamt_q);
                state_d   = WAIT;
            end
            WAIT: begin
                if (shf_done) begin
                    result_d = shf_data;
                    rsp_id_d = id_q;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    op_cnt_d = op_cnt_q + 32'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, operand and result registers; reset discards any in-flight op.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            rsp_id_q <= '0;
            arith_q  <= 1'b0;
            shamt_q  <= '0;
            data_q   <= '0;
            result_q <= '0;
            op_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            rsp_id_q <= rsp_id_d;
            arith_q  <= arith_d;
            shamt_q  <= shamt_d;
            data_q   <= data_d;
            result_q <= result_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    assign rsp_id_o   = rsp_id_q;
    assign rsp_data_o = result_q;
    assign op_cnt_o   = op_cnt_q;

    // The shifter may only report completion in the cycle the sequencer expects it.
    a_done_only_in_wait: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) shf_done |-> (state_q == WAIT)
    );

endmodule

// File: tb/tb_sra_64b_arb.sv
module tb_sra_64b_arb;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       req_arith;
    logic [N_REQ-1:0][5:0]  req_shamt;
    logic [N_REQ-1:0][63:0] req_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [63:0]            rsp_data;
    logic [31:0]            op_cnt;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = 32'd0;

    sra_64b_arb #(.N_REQ(N_REQ)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_arith_i (req_arith),
        .req_shamt_i (req_shamt),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .op_cnt_o    (op_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference shift: one position per step, filling with the sign when arithmetic.
    function automatic logic [63:0] model(input logic arith, input logic [5:0] shamt,
                                          input logic [63:0] data);
        logic [63:0] r;
        r = data;
        for (int i = 0; i < int'(shamt); i++) begin
            r = {arith & data[63], r[63:1]};
        end
        return r;
    endfunction

    task automatic drive_req(input int idx, input logic arith, input logic [5:0] shamt,
                             input logic [63:0] data);
        req_arith[idx] = arith;
        req_shamt[idx] = shamt;
        req_data[idx]  = data;
        req_valid[idx] = 1'b1;
    endtask

    // Called just after the handshake edge; waits for the response and checks it against the scoreboard.
    task automatic wait_rsp(input string tag, output int lat);
        exp_t e;
        lat = 0;
        while (!rsp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ":rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ":sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ":id"}, 64'(rsp_id), 64'(e.id));
            chk({tag, ":data"}, rsp_data, e.data);
        end
    endtask

    // One isolated request with rsp_ready held high; checks grant, latency, result and counter.
    task automatic single(input int idx, input logic arith, input logic [5:0] shamt,
                          input logic [63:0] data, input logic [63:0] exp, input string tag);
        int lat;
        @(posedge clk); #1;
        drive_req(idx, arith, shamt, data);
        @(negedge clk);
        chk({tag, ":ready"}, 64'(req_ready), 64'(4'b0001 << idx));
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        sb.push_back('{id: ID_W'(idx), data: exp});
        wait_rsp(tag, lat);
        chk({tag, ":latency"}, 64'(lat), 64'd3);
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        chk({tag, ":op_cnt"}, 64'(op_cnt), 64'(exp_cnt));
        chk({tag, ":valid_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int          lat;
        int          n;
        logic        a;
        logic [5:0]  s;
        logic [63:0] d;
        logic [63:0] hold_data;

        rst_n     = 1'b0;
        req_valid = '0;
        req_arith = '0;
        req_shamt = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset state, with a request presented to confirm ready stays low in reset.
        req_valid = 4'b0101;
        repeat (2) @(negedge clk);
        chk("rst:ready", 64'(req_ready), 64'd0);
        chk("rst:rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst:rsp_id", 64'(rsp_id), 64'd0);
        chk("rst:rsp_data", rsp_data, 64'd0);
        chk("rst:op_cnt", 64'(op_cnt), 64'd0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Directed single-operation cases.
        single(0, 1'b1, 6'd4, 64'h8000_0000_0000_0000, 64'hF800_0000_0000_0000, "t1_arith4");
        chk("t1:op_cnt_one", 64'(op_cnt), 64'd1);
        single(0, 1'b0, 6'd4, 64'h8000_0000_0000_0000, 64'h0800_0000_0000_0000, "t2_logic4");
        single(0, 1'b0, 6'd0, 64'h1234, 64'h1234, "t2_shamt0");
        single(0, 1'b1, 6'd63, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "t2_arith63");
        single(0, 1'b0, 6'd63, 64'h8000_0000_0000_0000, 64'h1, "t2_logic63");
        single(0, 1'b1, 6'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, "t2_arith0");
        for (int k = 0; k < 4; k++) begin
            a = 1'($urandom_range(0, 1));
            s = 6'($urandom_range(1, 62));
            d = {$urandom, $urandom};
            d[63] = k[0];
            single(0, a, s, d, model(a, s, d), "t2_rand");
        end
        // Requester 3 leaves the pointer wrapped back to 0.
        single(3, 1'b1, 6'd8, 64'hF0F0_0000_0000_00FF, 64'hFFF0_F000_0000_0000, "t2_req3");

        // All requesters valid continuously: grants rotate 0,1,2,3,0.
        @(posedge clk); #1;
        for (int i = 0; i < N_REQ; i++) begin
            drive_req(i, i[0], 6'(4 * i + 1), {8'(8'hA0 + i), 56'h12_3456_789A_BCDE});
        end
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (req_ready == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t3:grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            sb.push_back('{id: ID_W'(k % 4),
                           data: model(req_arith[k % 4], req_shamt[k % 4], req_data[k % 4])});
            @(posedge clk); #1;
            if (k == 4) req_valid = '0;
            wait_rsp("t3", lat);
            chk("t3:latency", 64'(lat), 64'd3);
            @(negedge clk);
            exp_cnt = exp_cnt + 32'd1;
            chk("t3:op_cnt", 64'(op_cnt), 64'(exp_cnt));
        end

        // Backpressure: response held for 10 cycles while another requester waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_req(1, 1'b1, 6'd12, 64'h9ABC_DEF0_1234_5678);
        hold_data = model(1'b1, 6'd12, 64'h9ABC_DEF0_1234_5678);
        @(negedge clk);
        chk("t4:ready", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drive_req(2, 1'b0, 6'd20, 64'h0FED_CBA9_8765_4321);
        sb.push_back('{id: 2'd1, data: hold_data});
        wait_rsp("t4", lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4:hold_valid", 64'(rsp_valid), 64'd1);
            chk("t4:hold_data", rsp_data, hold_data);
            chk("t4:hold_id", 64'(rsp_id), 64'd1);
            chk("t4:hold_ready", 64'(req_ready), 64'd0);
            chk("t4:hold_cnt", 64'(op_cnt), 64'(exp_cnt));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4:cnt_before_edge", 64'(op_cnt), 64'(exp_cnt));
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        chk("t4:cnt_release", 64'(op_cnt), 64'(exp_cnt));
        chk("t4:data_kept_idle", rsp_data, hold_data);
        chk("t4:next_grant", 64'(req_ready), 64'b0100);
        sb.push_back('{id: 2'd2, data: model(1'b0, 6'd20, 64'h0FED_CBA9_8765_4321)});
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        wait_rsp("t4b", lat);
        chk("t4b:latency", 64'(lat), 64'd3);
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        chk("t4b:op_cnt", 64'(op_cnt), 64'(exp_cnt));

        // Reset asserted while the operation sits in EXEC: it must vanish.
        @(posedge clk); #1;
        drive_req(0, 1'b1, 6'd3, 64'hFFFF_0000_FFFF_0000);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("t5:ready", 64'(req_ready), 64'd0);
        chk("t5:rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5:rsp_id", 64'(rsp_id), 64'd0);
        chk("t5:rsp_data", rsp_data, 64'd0);
        chk("t5:op_cnt", 64'(op_cnt), 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 32'd0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("t5:no_rsp", 64'(n), 64'd0);
        single(2, 1'b1, 6'd1, 64'h8000_0000_0000_0002, 64'hC000_0000_0000_0001, "t5_after");

        // Counter wrap from all-ones to zero.
        @(negedge clk);
        force dut.op_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.op_cnt_q;
        @(negedge clk);
        chk("t6:preset", 64'(op_cnt), 64'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        single(1, 1'b0, 6'd32, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_DEAD_BEEF, "t6_wrap");
        chk("t6:wrapped", 64'(op_cnt), 64'd0);

        chk("end:sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
